// File: rtl/pipe_stage_buf.sv
// Two-entry elastic pipeline register with a skid slot, flush and a
// saturating backpressure counter. in_ready depends only on registered state.
module pipe_stage_buf #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 197,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                accept;
  logic                pop;

  // Handshake outputs come straight from state; out_ctrl is zeroed when idle
  // so a stale control word can never look like a live write or branch.
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    out_ctrl  = out_valid ? main_ctrl_q : '0;
    out_data  = main_data_q;
    stall_cnt = stall_cnt_q;
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Next-state and slot movement; flush overrides every other event.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = HALF;
          end
        end
        HALF: begin
          if (accept && pop) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = HALF;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Count cycles where the head is held by downstream, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and slot registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 5, giving the control-signal field width (mem_to_reg, reg_write_en, mem_read, mem_write, branch).
REQ-002 The block SHALL have parameter DATA_W, default 197, giving the payload width (pc_next 64 + alu result 64 + store data 64 + rd 5).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the stall-counter width.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream stage presents a valid entry.
REQ-007 in_ready  output  1  block can accept an entry this cycle.
REQ-008 in_ctrl  input  CTRL_W  upstream control bits.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  head entry is valid.
REQ-011 out_ready  input  1  downstream stage consumes the head entry this cycle.
REQ-012 out_ctrl  output  CTRL_W  head control bits; forced to 0 when out_valid=0.
REQ-013 out_data  output  DATA_W  head payload.
REQ-014 flush  input  1  synchronous kill of all held entries (branch/exception squash).
REQ-015 stall_cnt  output  CNT_W  saturating count of backpressure cycles.

Function
REQ-016 The block SHALL be a 2-entry elastic register: main slot (drives outputs) plus skid slot, with states EMPTY (0 entries), HALF (main only) and FULL (main+skid).
REQ-017 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL be 1 exactly when state != FULL, and SHALL be a function of registered state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL be 1 exactly when state != EMPTY.
REQ-020 EMPTY + accept: the entry SHALL load into main, next state HALF; out_valid SHALL rise 1 cycle after accept.
REQ-021 HALF + accept + pop: the new entry SHALL load into main, state SHALL stay HALF, and throughput SHALL be 1 entry/cycle.
REQ-022 HALF + accept without pop: the entry SHALL load into skid, next state FULL.
REQ-023 HALF + pop without accept: next state SHALL be EMPTY.
REQ-024 FULL + pop: skid SHALL move to main, next state HALF; no accept is possible in FULL.
REQ-025 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated.
REQ-026 flush=1 SHALL set next state to EMPTY, ignore any simultaneous accept or pop, and take priority over all other events.
REQ-027 Payload registers MAY retain stale data after flush or pop; out_ctrl SHALL still read 0 whenever out_valid=0.
REQ-028 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 && out_ready=0 && flush=0, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-029 out_ctrl and out_data SHALL come directly from the main-slot registers with no combinational logic between in_* and out_*, except the zero gating of out_ctrl.

Reset
REQ-030 While reset=1 the block SHALL hold state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid slot=0 and stall_cnt=0, independent of clk.
REQ-031 After reset, in_ready SHALL be 1, including while reset is asserted.
REQ-032 Reset asserted mid-operation SHALL discard all held entries immediately; the first accept after deassertion SHALL behave as EMPTY + accept.

Verification
REQ-033 Streaming: out_ready=1, accept ctrl=5'h1F/data=1,2,3 on back-to-back cycles -> out_data 1,2,3 on consecutive cycles starting 1 cycle later; in_ready stays 1; stall_cnt=0.
REQ-034 Backpressure: out_ready=0, accept A=10 then B=20 -> FULL, in_ready=0, out_data=10; raise out_ready -> out_data 10 then 20, in_ready=1 after first pop; stall_cnt counts every held cycle.
REQ-035 Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; flushed and offered entries never appear at the output.
REQ-036 Saturation: CNT_W=4, out_valid=1, out_ready=0 held for 20 cycles -> stall_cnt reaches 15 and holds 15.
REQ-037 Async reset: assert reset between clock edges while FULL -> out_valid=0, out_data=0, stall_cnt=0 before the next edge; after deassertion, accept 7 -> out_data=7 next cycle.
REQ-038 Random: random in_valid/out_ready/flush for 10k cycles vs reference queue -> order preserved, no loss or duplication except flushed entries; out_ctrl=0 whenever out_valid=0.
